// File: rtl/alu_stack_seq.sv
// -----------------------------------------------------------------------------
// alu_stack_seq
// Accumulator ALU for the 4-bit-opcode CPU datapath. It adds a configurable
// datapath width, a LIFO hardware stack for PUSH/POP, carry/overflow flags and
// an optional iterative shift-add multiplier.
//
// Ports:
//   alu_clk    clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   start      operation request, sampled only while busy=0
//   opcode     4-bit operation code
//   data       operand from ROM/RAM
//   accum      operand from the accumulator
//   alu_out    registered result
//   zero       combinational, 1 when accum==0
//   carry      registered carry / borrow / shifted-out bit
//   ovf        registered signed or multiply overflow
//   busy       multi-cycle multiply in progress
//   done       one-cycle completion pulse
//   stk_full   stack holds STACK_DEPTH entries
//   stk_empty  stack holds no entries
//   stk_err    one-cycle pulse (with done) on push-to-full or pop-from-empty
//   sp         current stack occupancy
// -----------------------------------------------------------------------------
module alu_stack_seq #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8,
    parameter int MUL_SEQ     = 1
) (
    input  logic                           alu_clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [3:0]                     opcode,
    input  logic [WIDTH-1:0]               data,
    input  logic [WIDTH-1:0]               accum,
    output logic [WIDTH-1:0]               alu_out,
    output logic                           zero,
    output logic                           carry,
    output logic                           ovf,
    output logic                           busy,
    output logic                           done,
    output logic                           stk_full,
    output logic                           stk_empty,
    output logic                           stk_err,
    output logic [$clog2(STACK_DEPTH):0]   sp
);

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int AW    = $clog2(STACK_DEPTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_LDA  = 4'hA;
    localparam logic [3:0] OP_RL   = 4'hB;
    localparam logic [3:0] OP_RR   = 4'hC;
    localparam logic [3:0] OP_POP  = 4'hE;
    localparam logic [3:0] OP_PUSH = 4'hF;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t                 state_reg;
    logic [WIDTH-1:0]       alu_out_reg;
    logic                   carry_reg;
    logic                   ovf_reg;
    logic                   done_reg;
    logic                   stk_err_reg;
    logic [SP_W-1:0]        sp_reg;
    logic [WIDTH-1:0]       mcand_reg;
    logic [2*WIDTH-1:0]     prod_reg;
    logic [CNT_W-1:0]       cnt_reg;

    logic [WIDTH-1:0]       stack_mem [STACK_DEPTH];

    logic                   accept;
    logic [SP_W-1:0]        sp_dec;
    logic [WIDTH:0]         add_ext;
    logic [WIDTH:0]         sub_ext;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     prod_step;
    logic [2*WIDTH-1:0]     prod_comb;

    logic [WIDTH-1:0]       res_next;
    logic                   carry_next;
    logic                   ovf_next;
    logic [SP_W-1:0]        sp_next;
    logic                   err_next;
    logic                   push_we;
    logic                   start_mul;

    assign accept    = start && (state_reg == ST_IDLE);
    assign stk_full  = (sp_reg == SP_W'(STACK_DEPTH));
    assign stk_empty = (sp_reg == '0);
    assign sp_dec    = sp_reg - SP_W'(1);

    assign add_ext = {1'b0, accum} + {1'b0, data};
    assign sub_ext = {1'b0, accum} - {1'b0, data};

    // Right-shifting partial product: the multiplier sits in the low half and
    // is consumed LSB first while the running sum grows into the high half.
    assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                     + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    assign prod_step = {mul_sum, prod_reg[WIDTH-1:1]};

    generate
        if (MUL_SEQ == 0) begin : g_mul_comb
            assign prod_comb = {{WIDTH{1'b0}}, accum} * {{WIDTH{1'b0}}, data};
        end else begin : g_mul_iter
            assign prod_comb = '0;
        end
    endgenerate

    // Result and flag selection for every single-cycle operation.
    always_comb begin
        res_next   = accum;
        carry_next = carry_reg;
        ovf_next   = ovf_reg;
        sp_next    = sp_reg;
        err_next   = 1'b0;
        push_we    = 1'b0;
        start_mul  = 1'b0;
        case (opcode)
            OP_ADD: begin
                res_next   = add_ext[WIDTH-1:0];
                carry_next = add_ext[WIDTH];
                ovf_next   = (accum[WIDTH-1] == data[WIDTH-1]) &&
                             (add_ext[WIDTH-1] != accum[WIDTH-1]);
            end
            OP_SUB: begin
                res_next   = sub_ext[WIDTH-1:0];
                carry_next = sub_ext[WIDTH];
                ovf_next   = (accum[WIDTH-1] != data[WIDTH-1]) &&
                             (sub_ext[WIDTH-1] != accum[WIDTH-1]);
            end
            OP_MUL: begin
                if (MUL_SEQ != 0) begin
                    start_mul = 1'b1;
                end else begin
                    res_next   = prod_comb[WIDTH-1:0];
                    carry_next = 1'b0;
                    ovf_next   = |prod_comb[2*WIDTH-1:WIDTH];
                end
            end
            OP_OR:  res_next = accum | data;
            OP_AND: res_next = accum & data;
            OP_XOR: res_next = accum ^ data;
            OP_NOT: res_next = ~data;
            OP_LDA: res_next = data;
            OP_RL: begin
                res_next   = {data[WIDTH-2:0], 1'b0};
                carry_next = data[WIDTH-1];
                ovf_next   = 1'b0;
            end
            OP_RR: begin
                res_next   = {1'b0, data[WIDTH-1:1]};
                carry_next = data[0];
                ovf_next   = 1'b0;
            end
            OP_POP: begin
                if (stk_empty) begin
                    res_next = '0;
                    err_next = 1'b1;
                end else begin
                    res_next = stack_mem[sp_dec[AW-1:0]];
                    sp_next  = sp_dec;
                end
            end
            OP_PUSH: begin
                res_next = alu_out_reg;
                if (stk_full) begin
                    err_next = 1'b1;
                end else begin
                    push_we = 1'b1;
                    sp_next = sp_reg + SP_W'(1);
                end
            end
            default: res_next = accum;   // HLT, SKZ, STO, JMP pass accum
        endcase
    end

    // Stack storage has no reset; occupancy lives in sp_reg.
    always_ff @(posedge alu_clk) begin
        if (accept && push_we) begin
            stack_mem[sp_reg[AW-1:0]] <= accum;
        end
    end

    always_ff @(posedge alu_clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            alu_out_reg <= '0;
            carry_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
            stk_err_reg <= 1'b0;
            sp_reg      <= '0;
            mcand_reg   <= '0;
            prod_reg    <= '0;
            cnt_reg     <= '0;
        end else begin
            done_reg    <= 1'b0;
            stk_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (start_mul) begin
                            state_reg <= ST_MUL;
                            mcand_reg <= accum;
                            prod_reg  <= {{WIDTH{1'b0}}, data};
                            cnt_reg   <= '0;
                        end else begin
                            alu_out_reg <= res_next;
                            carry_reg   <= carry_next;
                            ovf_reg     <= ovf_next;
                            sp_reg      <= sp_next;
                            stk_err_reg <= err_next;
                            done_reg    <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    prod_reg <= prod_step;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    // The last iteration's result goes straight to the output.
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_reg   <= ST_IDLE;
                        alu_out_reg <= prod_step[WIDTH-1:0];
                        ovf_reg     <= |prod_step[2*WIDTH-1:WIDTH];
                        carry_reg   <= 1'b0;
                        done_reg    <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign alu_out = alu_out_reg;
    assign carry   = carry_reg;
    assign ovf     = ovf_reg;
    assign done    = done_reg;
    assign stk_err = stk_err_reg;
    assign sp      = sp_reg;
    assign busy    = (state_reg == ST_MUL);
    assign zero    = (accum == '0);

endmodule

// File: tb/tb_alu_stack_seq.sv
module tb_alu_stack_seq;

    localparam int W   = 16;
    localparam int D   = 8;
    localparam int MS  = 1;
    localparam int SPW = $clog2(D) + 1;

    localparam logic [3:0] OP_HLT = 4'h0, OP_SKZ = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
    localparam logic [3:0] OP_MUL = 4'h4, OP_OR  = 4'h5, OP_AND = 4'h6, OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8, OP_STO = 4'h9, OP_LDA = 4'hA, OP_RL  = 4'hB;
    localparam logic [3:0] OP_RR  = 4'hC, OP_JMP = 4'hD, OP_POP = 4'hE, OP_PUSH = 4'hF;

    logic           alu_clk = 1'b0;
    logic           rst     = 1'b1;
    logic           start   = 1'b0;
    logic [3:0]     opcode  = 4'h0;
    logic [W-1:0]   data    = '0;
    logic [W-1:0]   accum   = '0;
    logic [W-1:0]   alu_out;
    logic           zero, carry, ovf, busy, done, stk_full, stk_empty, stk_err;
    logic [SPW-1:0] sp;

    alu_stack_seq #(.WIDTH(W), .STACK_DEPTH(D), .MUL_SEQ(MS)) dut (
        .alu_clk(alu_clk), .rst(rst), .start(start), .opcode(opcode),
        .data(data), .accum(accum), .alu_out(alu_out), .zero(zero),
        .carry(carry), .ovf(ovf), .busy(busy), .done(done),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err), .sp(sp)
    );

    always #5 alu_clk = ~alu_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] m_out;
    bit           m_carry, m_ovf, m_busy, m_done, m_err;
    int           m_cnt;
    longint       m_prod;
    logic [W-1:0] m_stack[$];
    longint       ma, md, mt, sa, sd, st;

    localparam longint MOD  = 64'sd1 <<< W;
    localparam longint HALF = 64'sd1 <<< (W - 1);

    function automatic longint to_signed(input longint v);
        return (v >= HALF) ? v - MOD : v;
    endfunction

    always @(posedge alu_clk or posedge rst) begin
        if (rst) begin
            m_out = '0; m_carry = 0; m_ovf = 0; m_busy = 0; m_done = 0; m_err = 0;
            m_cnt = 0; m_stack.delete();
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy  = 0;
                    m_done  = 1;
                    m_out   = W'(m_prod % MOD);
                    m_ovf   = (m_prod / MOD) != 0;
                    m_carry = 0;
                end
            end else if (start) begin
                ma = longint'(accum);
                md = longint'(data);
                sa = to_signed(ma);
                sd = to_signed(md);
                m_done = 1;
                case (opcode)
                    OP_ADD: begin
                        mt = ma + md; st = sa + sd;
                        m_out = W'(mt % MOD); m_carry = mt >= MOD;
                        m_ovf = (st >= HALF) || (st < -HALF);
                    end
                    OP_SUB: begin
                        mt = ma - md; if (mt < 0) mt = mt + MOD; st = sa - sd;
                        m_out = W'(mt); m_carry = ma < md;
                        m_ovf = (st >= HALF) || (st < -HALF);
                    end
                    OP_MUL: begin
                        m_prod = ma * md; m_busy = 1; m_cnt = W; m_done = 0;
                    end
                    OP_OR:  m_out = accum | data;
                    OP_AND: m_out = accum & data;
                    OP_XOR: m_out = accum ^ data;
                    OP_NOT: m_out = ~data;
                    OP_LDA: m_out = data;
                    OP_RL: begin
                        m_out = W'((md * 2) % MOD); m_carry = md >= HALF; m_ovf = 0;
                    end
                    OP_RR: begin
                        m_out = W'(md / 2); m_carry = (md % 2) == 1; m_ovf = 0;
                    end
                    OP_PUSH: begin
                        if (m_stack.size() < D) m_stack.push_back(accum);
                        else m_err = 1;
                    end
                    OP_POP: begin
                        if (m_stack.size() > 0) m_out = m_stack.pop_back();
                        else begin m_out = '0; m_err = 1; end
                    end
                    default: m_out = accum;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge alu_clk) begin
        if (chk_en) begin
            chk("cyc alu_out", alu_out, m_out);
            chk("cyc carry", carry, m_carry);
            chk("cyc ovf", ovf, m_ovf);
            chk("cyc busy", busy, m_busy);
            chk("cyc done", done, m_done);
            chk("cyc stk_err", stk_err, m_err);
            chk("cyc sp", sp, 64'(m_stack.size()));
            chk("cyc stk_full", stk_full, m_stack.size() == D);
            chk("cyc stk_empty", stk_empty, m_stack.size() == 0);
            chk("cyc zero", zero, accum == 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d);
        @(negedge alu_clk);
        #1;
        start = 1'b1; opcode = op; accum = a; data = d;
        $display("op=%h accum=%h data=%h", op, a, d);
        @(posedge alu_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit poke, output int nb, output bit got);
        nb  = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge alu_clk);
            if (busy) nb++;
            if (done) begin got = 1; break; end
            if (poke && i == 3) begin
                #1; start = 1'b1; opcode = OP_ADD; accum = 16'h1111; data = 16'h0001;
                @(posedge alu_clk);
                #1; start = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] d;
        logic [W-1:0] e;
    } vec_t;
    vec_t vecs[9];

    int nb;
    bit got;

    initial begin
        vecs[0] = '{OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0};
        vecs[1] = '{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000};
        vecs[2] = '{OP_XOR, 16'hFFFF, 16'h00FF, 16'hFF00};
        vecs[3] = '{OP_NOT, 16'h1234, 16'h00FF, 16'hFF00};
        vecs[4] = '{OP_LDA, 16'h9999, 16'h1234, 16'h1234};
        vecs[5] = '{OP_STO, 16'h5A5A, 16'h0001, 16'h5A5A};
        vecs[6] = '{OP_HLT, 16'h0000, 16'hABCD, 16'h0000};
        vecs[7] = '{OP_JMP, 16'h7777, 16'h0001, 16'h7777};
        vecs[8] = '{OP_SKZ, 16'h0042, 16'h0003, 16'h0042};

        repeat (2) @(negedge alu_clk);
        chk_en = 1;
        chk("reset alu_out", alu_out, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sp", sp, 0);
        chk("reset stk_empty", stk_empty, 1);
        #1 rst = 1'b0;

        // ADD with carry out
        issue(OP_ADD, 16'hFFFF, 16'h0001);
        @(negedge alu_clk);
        chk("add alu_out", alu_out, 16'h0000);
        chk("add carry", carry, 1);
        chk("add ovf", ovf, 0);
        chk("add done", done, 1);
        chk("add zero", zero, 0);
        @(negedge alu_clk);
        chk("add done drop", done, 0);

        // SUB signed overflow, then borrow
        issue(OP_SUB, 16'h8000, 16'h0001);
        @(negedge alu_clk);
        chk("sub1 alu_out", alu_out, 16'h7FFF);
        chk("sub1 carry", carry, 0);
        chk("sub1 ovf", ovf, 1);
        issue(OP_SUB, 16'h0001, 16'h0002);
        @(negedge alu_clk);
        chk("sub2 alu_out", alu_out, 16'hFFFF);
        chk("sub2 carry", carry, 1);

        // Logic / pass-through table
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].d);
            @(negedge alu_clk);
            chk("vec alu_out", alu_out, vecs[i].e);
        end

        // Back-to-back accepts
        issue(OP_LDA, 16'h0000, 16'h0010);
        issue(OP_ADD, 16'h0010, 16'h0005);
        issue(OP_XOR, 16'h00FF, 16'h0F0F);
        @(negedge alu_clk);
        chk("b2b alu_out", alu_out, 16'h0FF0);
        chk("b2b done", done, 1);

        // Rotates, then AND keeps carry
        issue(OP_RL, 16'h0000, 16'h8001);
        @(negedge alu_clk);
        chk("rl alu_out", alu_out, 16'h0002);
        chk("rl carry", carry, 1);
        issue(OP_RR, 16'h0000, 16'h8001);
        @(negedge alu_clk);
        chk("rr alu_out", alu_out, 16'h4000);
        chk("rr carry", carry, 1);
        issue(OP_AND, 16'hFFFF, 16'h0F0F);
        @(negedge alu_clk);
        chk("and alu_out", alu_out, 16'h0F0F);
        chk("and carry", carry, 1);

        // Sequential multiply with a mid-busy start
        issue(OP_MUL, 16'h0012, 16'h0034);
        wait_done(1'b1, nb, got);
        chk("mul1 done seen", got, 1);
        chk("mul1 busy cycles", 64'(nb), 16);
        chk("mul1 alu_out", alu_out, 16'h03A8);
        chk("mul1 ovf", ovf, 0);
        chk("mul1 carry", carry, 0);
        @(negedge alu_clk);
        chk("mul1 done drop", done, 0);
        issue(OP_MUL, 16'h1000, 16'h0010);
        wait_done(1'b0, nb, got);
        chk("mul2 done seen", got, 1);
        chk("mul2 alu_out", alu_out, 16'h0000);
        chk("mul2 ovf", ovf, 1);

        // Stack fill, overflow, drain, underflow
        for (int i = 1; i <= D; i++) issue(OP_PUSH, W'(i), 16'h0000);
        @(negedge alu_clk);
        chk("push sp", sp, D);
        chk("push full", stk_full, 1);
        issue(OP_PUSH, 16'h0009, 16'h0000);
        @(negedge alu_clk);
        chk("push9 err", stk_err, 1);
        chk("push9 sp", sp, D);
        for (int i = D; i >= 1; i--) begin
            issue(OP_POP, 16'h0000, 16'h0000);
            @(negedge alu_clk);
            chk("pop alu_out", alu_out, 64'(i));
        end
        chk("pop empty", stk_empty, 1);
        issue(OP_POP, 16'h0000, 16'h0000);
        @(negedge alu_clk);
        chk("pop9 alu_out", alu_out, 0);
        chk("pop9 err", stk_err, 1);

        // Reset in the middle of a multiply
        issue(OP_PUSH, 16'h0005, 16'h0000);
        issue(OP_PUSH, 16'h0006, 16'h0000);
        issue(OP_MUL, 16'h0003, 16'h0007);
        repeat (5) @(negedge alu_clk);
        chk("rstmul busy before", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmul busy", busy, 0);
        chk("rstmul alu_out", alu_out, 0);
        chk("rstmul sp", sp, 0);
        repeat (2) @(negedge alu_clk);
        chk("rstmul no done", done, 0);
        #1 rst = 1'b0;
        issue(OP_ADD, 16'h0002, 16'h0003);
        @(negedge alu_clk);
        chk("post rst add", alu_out, 16'h0005);
        chk("post rst done", done, 1);

        repeat (2) @(negedge alu_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_stack_seq.md
Name: alu_stack_seq

Overview:
Parametrised next-generation accumulator ALU for the 4-bit-opcode CPU datapath. It keeps the existing opcode map and adds the following:
- configurable datapath width;
- a real LIFO hardware stack of configurable depth for PUSH/POP;
- carry and overflow flags;
- an optional iterative shift-add multiplier.

Completion uses a start/busy/done handshake. The block sits between the controller (opcode, start) and the accumulator register (alu_out).

Parameters:
- WIDTH, 16, datapath width of data, accum and alu_out (>=4).
- STACK_DEPTH, 8, number of stack entries (power of two, >=2). SP_W = clog2(STACK_DEPTH)+1 is derived, not a parameter.
- MUL_SEQ, 1, 1 = iterative multiply taking WIDTH cycles; 0 = single-cycle multiply.

Ports:
- alu_clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  operation request; sampled only when busy=0
- opcode  in  4  HLT=0 SKZ=1 ADD=2 SUB=3 MUL=4 OR=5 AND=6 XOR=7 NOT=8 STO=9 LDA=A RL=B RR=C JMP=D POP=E PUSH=F
- data  in  WIDTH  operand from ROM/RAM
- accum  in  WIDTH  operand from accumulator
- alu_out  out  WIDTH  registered result
- zero  out  1  combinational, 1 when accum==0
- carry  out  1  registered carry/borrow/shifted-out bit
- ovf  out  1  registered signed/multiply overflow
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle completion pulse
- stk_full  out  1  sp==STACK_DEPTH (combinational from sp)
- stk_empty  out  1  sp==0 (combinational from sp)
- stk_err  out  1  one-cycle pulse with done on push-to-full or pop-from-empty
- sp  out  SP_W  current stack occupancy

Behaviour:

Reset (async, immediate on rst=1):
- alu_out=0, carry=0, ovf=0, busy=0, done=0, stk_err=0, sp=0.
- Stack RAM contents are not reset.

Reset mid-MUL:
- Aborts the multiply. busy drops at once; no done pulse.

Accept rule:
- An operation is accepted on a rising edge where start=1 and busy=0.
- start while busy=1 is ignored, not queued. Operands and opcode are captured at the accept edge.

Single-cycle ops (all except MUL with MUL_SEQ=1):
- Accepted at edge N. alu_out and flags are updated at edge N.
- done=1 from edge N to edge N+1. busy stays 0.
- Back-to-back accepts every cycle are legal.

Multi-cycle MUL (MUL_SEQ=1):
- States: IDLE, MUL.
- IDLE->MUL at the accept edge N: busy=1; multiplicand, multiplier and a 2*WIDTH partial product are latched; iteration counter = 0.
- Each edge in MUL: conditional add of the multiplicand on multiplier LSB, shift, counter+1.
- At edge N+WIDTH: MUL->IDLE, busy=0, done=1 for one cycle.
  - alu_out = low WIDTH bits of accum*data.
  - ovf = (high WIDTH bits != 0).
  - carry = 0.
- alu_out and flags hold their previous values while busy.

Results (W=WIDTH, unsigned unless noted):
- ADD: {carry,alu_out}=accum+data; ovf = signed overflow.
- SUB: alu_out=accum-data; carry=borrow (accum<data); ovf = signed overflow.
- MUL (MUL_SEQ=0): same result and flags as sequential, in one cycle.
- OR/AND/XOR: bitwise of accum and data. NOT: ~data. LDA: data.
- RL: alu_out={data[W-2:0],1'b0}, carry=data[W-1]. RR: alu_out={1'b0,data[W-1:1]}, carry=data[0].
- HLT/SKZ/STO/JMP: alu_out=accum.
- carry and ovf change only on ADD, SUB, MUL, RL, RR; they hold otherwise. ovf is cleared by RL/RR.
- All 16 opcodes are decoded; no X is ever driven.

Stack:
- PUSH, not full: mem[sp]<=accum, sp<=sp+1; alu_out unchanged.
- PUSH, full: no write, sp unchanged, stk_err=1 with done.
- POP, not empty: alu_out<=mem[sp-1], sp<=sp-1.
- POP, empty: alu_out<=0, sp unchanged, stk_err=1 with done.
- PUSH/POP never alter carry or ovf.

Test Plan:
- ADD, accum=16'hFFFF, data=16'h0001 -> alu_out=16'h0000, carry=1, ovf=0; done high exactly one cycle at the accept edge; zero tracks accum only.
- SUB, accum=16'h8000, data=16'h0001 -> alu_out=16'h7FFF, carry=0, ovf=1. Then SUB with accum=1, data=2 -> alu_out=16'hFFFF, carry=1.
- MUL_SEQ=1, accum=16'h0012, data=16'h0034 -> busy high 16 cycles, then alu_out=16'h03A8, ovf=0, single done. A start pulse mid-busy is ignored. Then 16'h1000*16'h0010 -> alu_out=0, ovf=1.
- PUSH 1..8 -> sp=8, stk_full=1. 9th PUSH -> stk_err pulse, sp=8. Eight POPs -> alu_out 8,7,...,1, stk_empty=1. 9th POP -> alu_out=0, stk_err pulse.
- rst asserted 5 cycles into a MUL -> busy=0, alu_out=0, sp=0 asynchronously, no done. An ADD after release completes normally.
- RL with data=16'h8001 -> alu_out=16'h0002, carry=1. RR with data=16'h8001 -> alu_out=16'h4000, carry=1. A following AND leaves carry at 1.
